// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
// Holds the FSM state encoding, byte width and default operand size.
package mp_add_pkg;

  localparam int MP_BYTE_W     = 8;
  localparam int MP_NBYTES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mp_add_if.sv
// Operand/result handshake bundle for mp_add_seq.
// master = producer/consumer side, slave = sequencer side.
interface mp_add_if
  import mp_add_pkg::*;
#(
  parameter int NBYTES = MP_NBYTES_DEF
);

  localparam int W = MP_BYTE_W * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/adder_8bit.sv
// 8-bit ripple adder slice with carry in/out.
// Ports: x, y, carry_in -> sum, final_carry_out.
module adder_8bit (
  output logic [7:0] sum,
  output logic       final_carry_out,
  input  logic       carry_in,
  input  logic [7:0] x,
  input  logic [7:0] y
);

  assign {final_carry_out, sum} =
    {1'b0, x} + {1'b0, y} + {8'd0, carry_in};

endmodule

// File: rtl/mp_add_seq.sv
// Wide adder that reuses one adder_8bit over NBYTES cycles, LSB first.
// Ports: clk, rst (sync, active-high), bus (slave handshake), busy.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int NBYTES = MP_NBYTES_DEF
) (
  input  logic     clk,
  input  logic     rst,
  mp_add_if.slave  bus,
  output logic     busy
);

  localparam int W     = MP_BYTE_W * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  state_e state_q, state_d;

  logic [W-1:0]     a_q, b_q, sum_q;
  logic             c_q, cout_q;
  logic [IDX_W-1:0] idx_q;

  logic [7:0]       add_x, add_y, add_s;
  logic             add_co;
  logic [IDX_W+2:0] off;
  logic             accept, last;

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign last   = (idx_q == LAST);
  assign off    = {idx_q, 3'b000};
  assign add_x  = a_q[off +: MP_BYTE_W];
  assign add_y  = b_q[off +: MP_BYTE_W];

  adder_8bit u_add (
    .sum             (add_s),
    .final_carry_out (add_co),
    .carry_in        (c_q),
    .x               (add_x),
    .y               (add_y)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    busy          = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      idx_q  <= '0;
    end else if (accept) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      c_q   <= bus.cin;
      idx_q <= '0;
    end else if (state_q == RUN) begin
      sum_q[off +: MP_BYTE_W] <= add_s;
      c_q   <= add_co;
      idx_q <= idx_q + 1'b1;
      if (last) cout_q <= add_co;
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add sequencer. Computes an (8*NBYTES)-bit sum by time-multiplexing one adder_8bit instance over NBYTES cycles, least-significant byte first, chaining carry between bytes.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- It is the controller that sequences the 8-bit adder datapath for wide operands.

Parameters:
- NBYTES, 4: operand width in bytes; legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- a  input  8*NBYTES  operand A.
- b  input  8*NBYTES  operand B.
- cin  input  1  carry into byte 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  8*NBYTES  result.
- cout  output  1  carry out of the most-significant byte.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, byte index=0, carry reg=0.
- States are IDLE, RUN and DONE.
- in_ready is asserted only in IDLE. out_valid is asserted only in DONE. busy = (state != IDLE).
- IDLE:
  - On an edge with in_valid&&in_ready, latch a, b and cin into internal registers (carry reg <= cin), set idx <= 0 and go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Adder inputs are x = a_reg byte idx, y = b_reg byte idx, carry_in = carry reg.
  - Each edge: sum byte idx <= adder sum; carry reg <= final_carry_out; idx <= idx+1.
  - On the edge where idx == NBYTES-1: also cout <= final_carry_out and go to DONE.
- DONE:
  - Hold sum and cout stable.
  - On an edge with out_ready=1, go to IDLE. in_ready is high the following cycle.
- Latency: if the operands are accepted at edge t, out_valid is high after edge t+NBYTES. The minimum issue interval is NBYTES+2 cycles.
- Input isolation: changes on a, b and cin after acceptance have no effect on the result. in_valid is ignored outside IDLE.
- Width rules:
  - Result is modulo 2^(8*NBYTES); the overflow indication is cout.
  - idx width is clog2(NBYTES), minimum 1 bit.
  - With NBYTES=1 the block passes through RUN for exactly one cycle.
- sum contents are don't-care while out_valid=0. Intermediate bytes may be visible during RUN.
- Reset in any state, including mid-RUN or DONE with out_ready=0: the operation is abandoned and all registers return to their reset values on that edge. No out_valid is produced for the abandoned operation.
- Simultaneous rst and in_valid: rst wins; nothing is accepted.
- out_ready high while not in DONE has no effect.

Decomposition:
- Shared package mp_add_pkg holds:
  - state typedef (enum IDLE, RUN, DONE, 2 bits);
  - constant MP_BYTE_W = 8;
  - default NBYTES constant.
- One sub-module: the existing adder_8bit, instantiated once with ports sum, final_carry_out, carry_in, x, y.
- The FSM, byte index and operand/result registers stay in mp_add_seq.

Test Plan:
- Reset: assert rst for 2 cycles, including during RUN -> in_ready=1, out_valid=0, busy=0, sum=0, cout=0 the cycle after rst drops.
- Byte carry: a=0x000000FF, b=0x00000001, cin=0, accepted at edge t -> out_valid after edge t+4, sum=0x00000100, cout=0.
- Full ripple with cin: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1. Mid-op, change a and b to 0x12121212 -> result unaffected.
- Backpressure: result 0x80000000+0x80000000 -> sum=0x00000000, cout=1. Hold out_ready=0 for 5 cycles while in_valid=1 -> out_valid, sum and cout stable; in_ready=0; no second acceptance. Raise out_ready -> IDLE, in_ready=1 next cycle.
- Abort: accept 0xAAAAAAAA+0x55555555, then pulse rst two edges later -> no out_valid for it. Then 0x12345678+0x11111111, cin=0 -> sum=0x23456789, cout=0.
- NBYTES=1 instance: a=128, b=129, cin=0 -> sum=1, cout=1, out_valid after 1 edge. Then a=1, b=29, cin=1 -> sum=31, cout=0.
